ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_b, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ID_EX, input, 230, decode bundle: [31:0] RsData, [63:32] RtData, [68:64] Rs, [73:69] Rt, [78:74] Rd, [87:79] {ALUSrc1,ALUSrc2,ALUFun[5:0],Sign}, [119:88] branch_address, [121:120] {MemRead,MemWrite}, [124:122] {MemToReg[1:0],RegWrite}, [157:125] {LUOp,LUData}, [189:158] PC_Plus4, [194:190] Shamt, [226:195] Imm32, [227] Branch, [229:228] RegDst.
REQ-004 SHALL have ports MEM_WB_RegWrite (in, 1), MEM_WB_Rd (in, 5) and MEM_WB_RdData (in, 32), the write-back forwarding source.
REQ-005 SHALL have port PCSrcB, output, 1, branch taken, combinational.
REQ-006 SHALL have port branch_target, output, 32, equal to ID_EX[119:88].
REQ-007 SHALL have port EX_MEM, output reg, 106: [31:0] ALUOut, [63:32] StoreData, [68:64] WriteReg, [69] MemRead, [70] MemWrite, [72:71] MemToReg, [73] RegWrite, [105:74] PC_Plus4.
REQ-008 SHALL have ports EX_MEM_RegWrite (out, 1), EX_MEM_Rd (out, 5) and EX_MEM_RdData (out, 32), the forwarding view of the EX_MEM register.

Function
REQ-009 SHALL form operand A = ALUSrc1 ? {27'b0,Shamt} : RsFwd, and operand B = ALUSrc2 ? Imm32 : RtFwd.
REQ-010 SHALL select RsFwd with this priority: (EX_MEM_RegWrite && EX_MEM_Rd!=0 && EX_MEM_Rd==Rs) -> EX_MEM_RdData; else the same test on MEM_WB -> MEM_WB_RdData; else RsData. RtFwd SHALL use the same rule with Rt.
REQ-011 SHALL support ALUFun codes ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111; any other code SHALL yield 0.
REQ-012 SHALL compute shifts as B shifted by A[4:0]; LT SHALL be signed when Sign=1 and unsigned otherwise; compare results SHALL be {31'b0,flag}; add/sub SHALL wrap modulo 2^32 with no overflow trap.
REQ-013 SHALL set ALUOut = LUOp ? LUData : ALU result.
REQ-014 SHALL select WriteReg by RegDst: 00 Rd, 01 Rt, 10 31, 11 26.
REQ-015 SHALL drive PCSrcB = Branch && ALU result[0], combinationally within the same cycle.
REQ-016 SHALL write EX_MEM one cycle after ID_EX presents the instruction: ALUOut, StoreData=RtFwd, WriteReg, control bits, PC_Plus4.
REQ-017 SHALL ensure a branch instruction (Branch=1) writes EX_MEM with RegWrite=0, MemRead=0 and MemWrite=0, whether or not the branch is taken.
REQ-018 SHALL accept an all-zero ID_EX (bubble) and produce EX_MEM control bits all 0.
REQ-019 SHALL drive EX_MEM_RdData = (MemToReg==2'b10) ? EX_MEM PC_Plus4 : EX_MEM ALUOut; EX_MEM_Rd = WriteReg; EX_MEM_RegWrite = RegWrite.
REQ-020 SHALL, when EX_MEM and MEM_WB both match the same register, take the EX_MEM value.

Reset
REQ-021 SHALL clear EX_MEM to 0 asynchronously while reset_b=0; PCSrcB SHALL be 0 whenever ID_EX is 0.
REQ-022 SHALL, on reset mid-operation, discard the in-flight result; the first post-reset edge SHALL capture ID_EX normally.

Configuration
REQ-023 SHALL implement forwarding (REQ-010, REQ-020) when EX_FORWARD_EN is defined.
REQ-024 SHALL, when EX_FORWARD_EN is undefined, use RsFwd=RsData and RtFwd=RtData; the EX_MEM_* forwarding outputs SHALL still be driven.

Structure
REQ-025 SHALL take the ALUFun codes, RegDst/MemToReg encodings and the ID_EX/EX_MEM field bounds from a shared package cpu_pkg.
REQ-026 SHALL place the arithmetic in one sub-module, alu (A, B, ALUFun, Sign -> Result), which is purely combinational; registers SHALL live in ex_stage only.

Verification
REQ-027 SHALL cover ADD: RsData=5, RtData=7, ALUFun=000000, RegDst=00, Rd=8, RegWrite=1 -> next cycle ALUOut=12, WriteReg=8, EX_MEM_RdData=12.
REQ-028 SHALL cover EX_MEM forwarding: instruction 1 writes $8=12; instruction 2 is SUB with Rs=8 and stale RsData=0, RtData=2 -> ALUOut=10; with EX_FORWARD_EN undefined -> 0xFFFFFFFE.
REQ-029 SHALL cover priority: EX_MEM $9=1 and MEM_WB $9=2 both valid, Rs=9 passed through PASSA -> ALUOut=1; Rs=0 with MEM_WB_Rd=0 -> RsData used.
REQ-030 SHALL cover branch: Branch=1, EQ, Rs=Rt=3, branch_address=0x40 -> PCSrcB=1 and branch_target=0x40 in the same cycle; EX_MEM RegWrite/MemWrite=0. With Rt=4 -> PCSrcB=0.
REQ-031 SHALL cover LT: A=0xFFFFFFFF, B=1, Sign=1 -> 1; Sign=0 -> 0. SRA with Shamt=4, B=0x80000000 -> 0xF8000000.
REQ-032 SHALL cover jal and reset: RegDst=10, MemToReg=10, PC_Plus4=0x104 -> WriteReg=31, EX_MEM_RdData=0x104; reset_b low mid-stream -> EX_MEM=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU function codes, RegDst/MemToReg encodings and the
// ID_EX / EX_MEM pipeline register layouts.
package cpu_pkg;

  localparam int ID_EX_W  = 230;
  localparam int EX_MEM_W = 106;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111011;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  localparam logic [1:0] REGDST_RD = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_XP = 2'b11;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_XP = 5'd26;

  // Field order is MSB first, so the struct bit ranges match the bus layout.
  typedef struct packed {
    logic [1:0]  reg_dst;        // [229:228]
    logic        branch;         // [227]
    logic [31:0] imm32;          // [226:195]
    logic [4:0]  shamt;          // [194:190]
    logic [31:0] pc_plus4;       // [189:158]
    logic        lu_op;          // [157]
    logic [31:0] lu_data;        // [156:125]
    logic [1:0]  mem_to_reg;     // [124:123]
    logic        reg_write;      // [122]
    logic        mem_read;       // [121]
    logic        mem_write;      // [120]
    logic [31:0] branch_address; // [119:88]
    logic        alu_src1;       // [87]
    logic        alu_src2;       // [86]
    logic [5:0]  alu_fun;        // [85:80]
    logic        sign;           // [79]
    logic [4:0]  rd;             // [78:74]
    logic [4:0]  rt;             // [73:69]
    logic [4:0]  rs;             // [68:64]
    logic [31:0] rt_data;        // [63:32]
    logic [31:0] rs_data;        // [31:0]
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc_plus4;       // [105:74]
    logic        reg_write;      // [73]
    logic [1:0]  mem_to_reg;     // [72:71]
    logic        mem_write;      // [70]
    logic        mem_read;       // [69]
    logic [4:0]  write_reg;      // [68:64]
    logic [31:0] store_data;     // [63:32]
    logic [31:0] alu_out;        // [31:0]
  } ex_mem_t;

  function automatic logic [4:0] sel_write_reg(input logic [1:0] reg_dst,
                                               input logic [4:0] rd,
                                               input logic [4:0] rt);
    case (reg_dst)
      REGDST_RD: return rd;
      REGDST_RT: return rt;
      REGDST_RA: return REG_RA;
      default:   return REG_XP;
    endcase
  endfunction

  // $0 is hardwired, so a pending write to it never forwards.
  function automatic logic fwd_hit(input logic we, input logic [4:0] dst,
                                   input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Signal bundle around the execute stage: decode input, write-back forwarding
// source, branch outputs and the EX_MEM register with its forwarding view.
interface ex_stage_if;
  import cpu_pkg::*;

  logic [ID_EX_W-1:0]  ID_EX;
  logic                MEM_WB_RegWrite;
  logic [4:0]          MEM_WB_Rd;
  logic [31:0]         MEM_WB_RdData;
  logic                PCSrcB;
  logic [31:0]         branch_target;
  logic [EX_MEM_W-1:0] EX_MEM;
  logic                EX_MEM_RegWrite;
  logic [4:0]          EX_MEM_Rd;
  logic [31:0]         EX_MEM_RdData;

  modport master (
    output ID_EX, MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData,
    input  PCSrcB, branch_target, EX_MEM, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData
  );

  modport slave (
    input  ID_EX, MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData,
    output PCSrcB, branch_target, EX_MEM, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData
  );
endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; unlisted function codes produce zero.
module alu
  import cpu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALUFun,
  input  logic        Sign,
  output logic [31:0] Result
);

  logic w_lt;

  assign w_lt = Sign ? ($signed(A) < $signed(B)) : (A < B);

  // Shifts move B by A[4:0] so the shamt path can feed operand A.
  always_comb begin
    Result = 32'd0;
    case (ALUFun)
      ALU_ADD:   Result = A + B;
      ALU_SUB:   Result = A - B;
      ALU_AND:   Result = A & B;
      ALU_OR:    Result = A | B;
      ALU_XOR:   Result = A ^ B;
      ALU_NOR:   Result = ~(A | B);
      ALU_PASSA: Result = A;
      ALU_SLL:   Result = B << A[4:0];
      ALU_SRL:   Result = B >> A[4:0];
      ALU_SRA:   Result = 32'($signed(B) >>> A[4:0]);
      ALU_EQ:    Result = {31'd0, A == B};
      ALU_NEQ:   Result = {31'd0, A != B};
      ALU_LT:    Result = {31'd0, w_lt};
      ALU_LEZ:   Result = {31'd0, A[31] || (A == 32'd0)};
      ALU_LTZ:   Result = {31'd0, A[31]};
      ALU_GTZ:   Result = {31'd0, !A[31] && (A != 32'd0)};
      default:   Result = 32'd0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch decision and the EX_MEM register.
// Forwarding from EX_MEM / MEM_WB is built only when EX_FORWARD_EN is defined.
module ex_stage
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset_b,
  input  logic [ID_EX_W-1:0]  ID_EX,
  input  logic                MEM_WB_RegWrite,
  input  logic [4:0]          MEM_WB_Rd,
  input  logic [31:0]         MEM_WB_RdData,
  output logic                PCSrcB,
  output logic [31:0]         branch_target,
  output logic [EX_MEM_W-1:0] EX_MEM,
  output logic                EX_MEM_RegWrite,
  output logic [4:0]          EX_MEM_Rd,
  output logic [31:0]         EX_MEM_RdData
);

  id_ex_t      w_id;
  ex_mem_t     r_ex_mem;
  ex_mem_t     w_ex_mem_next;
  logic [31:0] w_rs_fwd;
  logic [31:0] w_rt_fwd;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_result;

  assign w_id = ID_EX;

`ifdef EX_FORWARD_EN
  // EX_MEM is checked last so the younger producer wins when both match.
  always_comb begin
    w_rs_fwd = w_id.rs_data;
    if (fwd_hit(MEM_WB_RegWrite, MEM_WB_Rd, w_id.rs)) w_rs_fwd = MEM_WB_RdData;
    if (fwd_hit(EX_MEM_RegWrite, EX_MEM_Rd, w_id.rs)) w_rs_fwd = EX_MEM_RdData;
    w_rt_fwd = w_id.rt_data;
    if (fwd_hit(MEM_WB_RegWrite, MEM_WB_Rd, w_id.rt)) w_rt_fwd = MEM_WB_RdData;
    if (fwd_hit(EX_MEM_RegWrite, EX_MEM_Rd, w_id.rt)) w_rt_fwd = EX_MEM_RdData;
  end
`else
  logic w_unused_fwd;

  assign w_rs_fwd     = w_id.rs_data;
  assign w_rt_fwd     = w_id.rt_data;
  assign w_unused_fwd = ^{MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData, w_id.rs, w_id.rt};
`endif

  assign w_op_a = w_id.alu_src1 ? {27'd0, w_id.shamt} : w_rs_fwd;
  assign w_op_b = w_id.alu_src2 ? w_id.imm32 : w_rt_fwd;

  alu u_alu (
    .A      (w_op_a),
    .B      (w_op_b),
    .ALUFun (w_id.alu_fun),
    .Sign   (w_id.sign),
    .Result (w_alu_result)
  );

  assign PCSrcB        = w_id.branch && w_alu_result[0];
  assign branch_target = w_id.branch_address;

  // Branches never write registers or memory, taken or not.
  always_comb begin
    w_ex_mem_next            = '0;
    w_ex_mem_next.alu_out    = w_id.lu_op ? w_id.lu_data : w_alu_result;
    w_ex_mem_next.store_data = w_rt_fwd;
    w_ex_mem_next.write_reg  = sel_write_reg(w_id.reg_dst, w_id.rd, w_id.rt);
    w_ex_mem_next.mem_read   = w_id.mem_read  && !w_id.branch;
    w_ex_mem_next.mem_write  = w_id.mem_write && !w_id.branch;
    w_ex_mem_next.mem_to_reg = w_id.mem_to_reg;
    w_ex_mem_next.reg_write  = w_id.reg_write && !w_id.branch;
    w_ex_mem_next.pc_plus4   = w_id.pc_plus4;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_ex_mem <= '0;
    end else begin
      r_ex_mem <= w_ex_mem_next;
    end
  end

  assign EX_MEM          = r_ex_mem;
  assign EX_MEM_RegWrite = r_ex_mem.reg_write;
  assign EX_MEM_Rd       = r_ex_mem.write_reg;
  assign EX_MEM_RdData   = (r_ex_mem.mem_to_reg == MEMTOREG_PC4) ? r_ex_mem.pc_plus4
                                                                 : r_ex_mem.alu_out;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: each issued instruction pushes its expected
// EX_MEM image, popped and compared one clock later.
module tb_ex_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  reg_dst;
    logic        branch;
    logic [31:0] imm32;
    logic [4:0]  shamt;
    logic [31:0] pc4;
    logic        lu_op;
    logic [31:0] lu_data;
    logic [1:0]  m2r;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] baddr;
    logic        src1;
    logic        src2;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [4:0]  rs;
    logic [31:0] rt_data;
    logic [31:0] rs_data;
  } instr_t;

  typedef struct packed {
    logic [105:0] exmem;
    logic [31:0]  rd_data;
  } exp_t;

  logic clk;
  logic reset_b;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  string name_q[$];

  ex_stage_if bus ();

  ex_stage dut (
    .clk             (clk),
    .reset_b         (reset_b),
    .ID_EX           (bus.ID_EX),
    .MEM_WB_RegWrite (bus.MEM_WB_RegWrite),
    .MEM_WB_Rd       (bus.MEM_WB_Rd),
    .MEM_WB_RdData   (bus.MEM_WB_RdData),
    .PCSrcB          (bus.PCSrcB),
    .branch_target   (bus.branch_target),
    .EX_MEM          (bus.EX_MEM),
    .EX_MEM_RegWrite (bus.EX_MEM_RegWrite),
    .EX_MEM_Rd       (bus.EX_MEM_Rd),
    .EX_MEM_RdData   (bus.EX_MEM_RdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus layout written out bit by bit, independent of the RTL package.
  function automatic logic [229:0] pack(input instr_t t);
    logic [229:0] v;
    v = '0;
    v[31:0]    = t.rs_data;
    v[63:32]   = t.rt_data;
    v[68:64]   = t.rs;
    v[73:69]   = t.rt;
    v[78:74]   = t.rd;
    v[87:79]   = {t.src1, t.src2, t.fun, t.sign};
    v[119:88]  = t.baddr;
    v[121:120] = {t.mr, t.mw};
    v[124:122] = {t.m2r, t.rw};
    v[157:125] = {t.lu_op, t.lu_data};
    v[189:158] = t.pc4;
    v[194:190] = t.shamt;
    v[226:195] = t.imm32;
    v[227]     = t.branch;
    v[229:228] = t.reg_dst;
    return v;
  endfunction

  function automatic logic [105:0] mk_exmem(input logic [31:0] alu_out, input logic [31:0] store,
                                           input logic [4:0] wr, input logic mr, input logic mw,
                                           input logic [1:0] m2r, input logic rw,
                                           input logic [31:0] pc4);
    logic [105:0] v;
    v = '0;
    v[31:0]   = alu_out;
    v[63:32]  = store;
    v[68:64]  = wr;
    v[69]     = mr;
    v[70]     = mw;
    v[72:71]  = m2r;
    v[73]     = rw;
    v[105:74] = pc4;
    return v;
  endfunction

  task automatic push(input string name, input logic [105:0] exmem, input logic [31:0] rd_data);
    exp_t e;
    e.exmem   = exmem;
    e.rd_data = rd_data;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic issue(input instr_t t, input logic mwb_we, input logic [4:0] mwb_rd,
                       input logic [31:0] mwb_data);
    bus.ID_EX           = pack(t);
    bus.MEM_WB_RegWrite = mwb_we;
    bus.MEM_WB_Rd       = mwb_rd;
    bus.MEM_WB_RdData   = mwb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    instr_t t;
    reset_b = 1'b0;
    t = '0;
    issue(t, 1'b0, 5'd0, 32'd0);
    issue(t, 1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.EX_MEM !== 106'd0) begin
      failures++;
      $display("FAIL reset_exmem got=%h exp=0", bus.EX_MEM);
    end
    checks++;
    if (bus.PCSrcB !== 1'b0 || bus.EX_MEM_RdData !== 32'd0) begin
      failures++;
      $display("FAIL reset_outs pcsrc=%b rddata=%h exp=0/0", bus.PCSrcB, bus.EX_MEM_RdData);
    end
    reset_b = 1'b1;
  endtask

  task automatic test_add;
    instr_t t;
    exp_t e;
    string n;
    t = '0;
    t.rs_data = 32'd5; t.rt_data = 32'd7; t.fun = 6'b000000; t.rd = 5'd8; t.rw = 1'b1;
    t.pc4 = 32'h100;
    push("add", mk_exmem(32'd12, 32'd7, 5'd8, 1'b0, 1'b0, 2'b00, 1'b1, 32'h100), 32'd12);
    issue(t, 1'b0, 5'd0, 32'd0);
    e = exp_q.pop_front(); n = name_q.pop_front();
    checks++;
    if (bus.EX_MEM !== e.exmem || bus.EX_MEM_RdData !== e.rd_data) begin
      failures++;
      $display("FAIL %s got=%h/%h exp=%h/%h", n, bus.EX_MEM, bus.EX_MEM_RdData, e.exmem, e.rd_data);
    end
    checks++;
    if (bus.EX_MEM_Rd !== 5'd8 || bus.EX_MEM_RegWrite !== 1'b1) begin
      failures++;
      $display("FAIL add_fwd_view rd=%0d rw=%b exp=8/1", bus.EX_MEM_Rd, bus.EX_MEM_RegWrite);
    end
  endtask

  task automatic test_forward;
    instr_t t[2];
    exp_t e;
    string n;
    logic [31:0] r;
    t[0] = '0;
    t[0].rs_data = 32'd5; t[0].rt_data = 32'd7; t[0].rd = 5'd8; t[0].rw = 1'b1;
    t[1] = '0;
    t[1].fun = 6'b000001; t[1].rs = 5'd8; t[1].rs_data = 32'd0; t[1].rt_data = 32'd2;
    t[1].rd = 5'd10; t[1].rw = 1'b1; t[1].pc4 = 32'h104;
    r = FWD ? 32'd10 : 32'hFFFF_FFFE;
    push("fwd_producer", mk_exmem(32'd12, 32'd7, 5'd8, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0), 32'd12);
    push("fwd_exmem_sub", mk_exmem(r, 32'd2, 5'd10, 1'b0, 1'b0, 2'b00, 1'b1, 32'h104), r);
    for (int i = 0; i < 2; i++) begin
      issue(t[i], 1'b0, 5'd0, 32'd0);
      e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (bus.EX_MEM !== e.exmem || bus.EX_MEM_RdData !== e.rd_data) begin
        failures++;
        $display("FAIL %s got=%h/%h exp=%h/%h", n, bus.EX_MEM, bus.EX_MEM_RdData, e.exmem, e.rd_data);
      end
    end
  endtask

  task automatic test_priority;
    instr_t t[4];
    logic        we[4];
    logic [4:0]  wrd[4];
    logic [31:0] wd[4];
    exp_t e;
    string n;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) t[i] = '0;
    t[0].rs_data = 32'd1; t[0].rd = 5'd9; t[0].rw = 1'b1;
    we[0] = 1'b0; wrd[0] = 5'd0; wd[0] = 32'd0;
    t[1].fun = 6'b011010; t[1].rs = 5'd9; t[1].rs_data = 32'd7; t[1].rd = 5'd5; t[1].rw = 1'b1;
    we[1] = 1'b1; wrd[1] = 5'd9; wd[1] = 32'd2;
    t[2].fun = 6'b011010; t[2].rs = 5'd0; t[2].rs_data = 32'h55; t[2].rd = 5'd6; t[2].rw = 1'b1;
    we[2] = 1'b1; wrd[2] = 5'd0; wd[2] = 32'hAA;
    t[3].fun = 6'b011010; t[3].rs = 5'd12; t[3].rt = 5'd12; t[3].rd = 5'd7; t[3].mw = 1'b1;
    we[3] = 1'b1; wrd[3] = 5'd12; wd[3] = 32'h33;
    push("prio_producer", mk_exmem(32'd1, 32'd0, 5'd9, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0), 32'd1);
    r = FWD ? 32'd1 : 32'd7;
    push("prio_exmem_over_memwb", mk_exmem(r, 32'd0, 5'd5, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0), r);
    push("prio_reg0_no_fwd", mk_exmem(32'h55, 32'd0, 5'd6, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0), 32'h55);
    r = FWD ? 32'h33 : 32'd0;
    push("prio_memwb_store", mk_exmem(r, r, 5'd7, 1'b0, 1'b1, 2'b00, 1'b0, 32'd0), r);
    for (int i = 0; i < 4; i++) begin
      issue(t[i], we[i], wrd[i], wd[i]);
      e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (bus.EX_MEM !== e.exmem || bus.EX_MEM_RdData !== e.rd_data) begin
        failures++;
        $display("FAIL %s got=%h/%h exp=%h/%h", n, bus.EX_MEM, bus.EX_MEM_RdData, e.exmem, e.rd_data);
      end
    end
  endtask

  task automatic test_branch;
    instr_t t[4];
    logic   pc_exp[4];
    exp_t e;
    string n;
    for (int i = 0; i < 4; i++) begin
      t[i] = '0;
      t[i].fun = 6'b110011; t[i].rs_data = 32'd3; t[i].rt_data = 32'd3; t[i].branch = 1'b1;
      t[i].baddr = 32'h40; t[i].rw = 1'b1; t[i].mw = 1'b1; t[i].mr = 1'b1; t[i].rd = 5'd4;
    end
    t[1].rt_data = 32'd4;
    t[2].branch = 1'b0; t[2].mw = 1'b0; t[2].mr = 1'b0;
    t[3] = '0;
    pc_exp = '{1'b1, 1'b0, 1'b0, 1'b0};
    push("branch_taken", mk_exmem(32'd1, 32'd3, 5'd4, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0), 32'd1);
    push("branch_not_taken", mk_exmem(32'd0, 32'd4, 5'd4, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0), 32'd0);
    push("eq_not_branch", mk_exmem(32'd1, 32'd3, 5'd4, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0), 32'd1);
    push("bubble", 106'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.ID_EX = pack(t[i]);
      bus.MEM_WB_RegWrite = 1'b0;
      #1;
      checks++;
      if (bus.PCSrcB !== pc_exp[i] || bus.branch_target !== t[i].baddr) begin
        failures++;
        $display("FAIL branch_comb%0d pcsrc=%b tgt=%h exp=%b/%h", i, bus.PCSrcB, bus.branch_target,
                 pc_exp[i], t[i].baddr);
      end
      issue(t[i], 1'b0, 5'd0, 32'd0);
      e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (bus.EX_MEM !== e.exmem || bus.EX_MEM_RdData !== e.rd_data) begin
        failures++;
        $display("FAIL %s got=%h/%h exp=%h/%h", n, bus.EX_MEM, bus.EX_MEM_RdData, e.exmem, e.rd_data);
      end
    end
  endtask

  typedef struct packed {
    logic [5:0]  fun;
    logic        src1;
    logic        src2;
    logic        sign;
    logic        lu_op;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] res;
  } alu_row_t;

  task automatic test_alu_back_to_back;
    alu_row_t rows[16];
    instr_t t;
    exp_t e;
    string n;
    rows = '{
      '{6'b110101, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1},
      '{6'b110101, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0},
      '{6'b100011, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'd0, 32'h8000_0000, 32'd0, 32'hF800_0000},
      '{6'b100001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'd0, 32'h8000_0000, 32'd0, 32'h0080_0000},
      '{6'b100000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'd0, 32'h1234_5678, 32'd0, 32'h3456_7800},
      '{6'b011000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'h00F0_1234},
      '{6'b011110, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hF000_0000, 32'h0000_000F, 32'd0, 32'hF000_000F},
      '{6'b010110, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0, 32'hF00F_F00F},
      '{6'b010001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_FFFF, 32'h00FF_0000, 32'd0, 32'hFF00_0000},
      '{6'b110001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd3, 32'd4, 32'd0, 32'd1},
      '{6'b111101, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd1},
      '{6'b111011, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd1},
      '{6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      '{6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd1, 32'd9, 32'hFFFF_FFFF, 32'd0},
      '{6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd5, 32'd7, 32'd0, 32'd0},
      '{6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 32'hABCD_0000}
    };
    foreach (rows[i]) begin
      t = '0;
      t.fun = rows[i].fun; t.src1 = rows[i].src1; t.src2 = rows[i].src2; t.sign = rows[i].sign;
      t.lu_op = rows[i].lu_op; t.lu_data = 32'hABCD_0000; t.shamt = rows[i].shamt;
      t.rs_data = rows[i].a; t.rt_data = rows[i].b; t.imm32 = rows[i].imm; t.rd = 5'd3;
      push($sformatf("alu_row%0d", i),
           mk_exmem(rows[i].res, rows[i].b, 5'd3, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0), rows[i].res);
      issue(t, 1'b0, 5'd0, 32'd0);
      e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (bus.EX_MEM !== e.exmem || bus.EX_MEM_RdData !== e.rd_data) begin
        failures++;
        $display("FAIL %s got=%h/%h exp=%h/%h", n, bus.EX_MEM, bus.EX_MEM_RdData, e.exmem, e.rd_data);
      end
    end
  endtask

  task automatic test_jal_regdst;
    instr_t t[3];
    exp_t e;
    string n;
    for (int i = 0; i < 3; i++) begin
      t[i] = '0;
      t[i].rs_data = 32'h10; t[i].rt_data = 32'h20; t[i].rw = 1'b1; t[i].pc4 = 32'h104;
      t[i].rd = 5'd8; t[i].rt = 5'd13;
    end
    t[0].reg_dst = 2'b10; t[0].m2r = 2'b10;
    t[1].reg_dst = 2'b11;
    t[2].reg_dst = 2'b01;
    push("jal", mk_exmem(32'h30, 32'h20, 5'd31, 1'b0, 1'b0, 2'b10, 1'b1, 32'h104), 32'h104);
    push("regdst_26", mk_exmem(32'h30, 32'h20, 5'd26, 1'b0, 1'b0, 2'b00, 1'b1, 32'h104), 32'h30);
    push("regdst_rt", mk_exmem(32'h30, 32'h20, 5'd13, 1'b0, 1'b0, 2'b00, 1'b1, 32'h104), 32'h30);
    for (int i = 0; i < 3; i++) begin
      issue(t[i], 1'b0, 5'd0, 32'd0);
      e = exp_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (bus.EX_MEM !== e.exmem || bus.EX_MEM_RdData !== e.rd_data) begin
        failures++;
        $display("FAIL %s got=%h/%h exp=%h/%h", n, bus.EX_MEM, bus.EX_MEM_RdData, e.exmem, e.rd_data);
      end
    end
  endtask

  task automatic test_reset_mid;
    instr_t t;
    exp_t e;
    string n;
    t = '0;
    t.rs_data = 32'd5; t.rt_data = 32'd7; t.rd = 5'd8; t.rw = 1'b1; t.pc4 = 32'h200;
    issue(t, 1'b0, 5'd0, 32'd0);
    #2;
    reset_b = 1'b0;
    #1;
    checks++;
    if (bus.EX_MEM !== 106'd0 || bus.EX_MEM_RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", bus.EX_MEM);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.EX_MEM !== 106'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", bus.EX_MEM);
    end
    reset_b = 1'b1;
    t.rs_data = 32'd20;
    push("post_reset_capture", mk_exmem(32'd27, 32'd7, 5'd8, 1'b0, 1'b0, 2'b00, 1'b1, 32'h200), 32'd27);
    issue(t, 1'b0, 5'd0, 32'd0);
    e = exp_q.pop_front(); n = name_q.pop_front();
    checks++;
    if (bus.EX_MEM !== e.exmem || bus.EX_MEM_RdData !== e.rd_data) begin
      failures++;
      $display("FAIL %s got=%h/%h exp=%h/%h", n, bus.EX_MEM, bus.EX_MEM_RdData, e.exmem, e.rd_data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_b  = 1'b0;
    bus.ID_EX           = '0;
    bus.MEM_WB_RegWrite = 1'b0;
    bus.MEM_WB_Rd       = 5'd0;
    bus.MEM_WB_RdData   = 32'd0;
    test_reset();
    test_add();
    test_forward();
    test_priority();
    test_branch();
    test_alu_back_to_back();
    test_jal_regdst();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
